// File: rtl/embed_sched_pkg.sv
// Shared definitions for the embedded-RAM scheduler: state encodings,
// parameter defaults and the frame-length consistency check.
package embed_sched_pkg;

  localparam int ADDR_W_DEF   = 12;
  localparam int FILL_LEN_DEF = 4096;
  localparam int RD_LAT_DEF   = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_SERVE   = 3'd3,
    ST_HANDOFF = 3'd4,
    ST_MLP     = 3'd5
  } sched_state_t;

  // The embed write address must wrap to 0 at the end of every frame,
  // so one frame has to cover the whole address space exactly.
  function automatic bit fill_len_ok(input int addr_w, input int fill_len);
    return (fill_len == (32'sd1 << addr_w));
  endfunction

endpackage

// File: rtl/embed_ram_sched_rd_lat_pipe.sv
// Read-valid tracking pipe: one stage for the registered read address plus
// the RAM read latency. o_empty means no read is still in flight.
module rd_lat_pipe
  import embed_sched_pkg::*;
#(
  parameter int DEPTH = RD_LAT_DEF + 1
) (
  input  logic s_clk,
  input  logic s_rst,
  input  logic i_vld,
  output logic o_vld,
  output logic o_empty
);

  logic [DEPTH-1:0] pipe_r;

  // Shift the grant flag towards the RAM data-valid output.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      pipe_r <= {DEPTH{1'b0}};
    end else begin
      pipe_r <= {pipe_r[DEPTH-2:0], i_vld};
    end
  end

  assign o_vld   = pipe_r[DEPTH-1];
  assign o_empty = (pipe_r == {DEPTH{1'b0}});

endmodule

// File: rtl/embed_ram_sched.sv
// Embedded RAM scheduler for the patch-embed stage. Sequences the frame
// fill stream, the attention reader and the MLP port so that no user ever
// collides on the RAM ports.
// Optional build macro EMBED_SCHED_PERF_EN adds saturating read-grant and
// read-stall counters (o_perf_rd_cnt, o_perf_stall_cnt).
module embed_ram_sched
  import embed_sched_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int FILL_LEN = FILL_LEN_DEF,
  parameter int RD_LAT   = RD_LAT_DEF
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_start,
  output logic              o_start_ack,
  input  logic              i_fill_valid,
  output logic              o_fill_en,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_gnt,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_valid,
  input  logic              i_mlp_req,
  output logic              o_mlp_gnt,
  input  logic              i_mlp_done,
  output logic              o_switch,
  output logic              o_frame_done,
  output logic              o_overrun,
  output logic [2:0]        o_state
`ifdef EMBED_SCHED_PERF_EN
  ,
  output logic [31:0]       o_perf_rd_cnt,
  output logic [31:0]       o_perf_stall_cnt
`endif
);

  localparam int CNT_W  = ADDR_W + 1;
  localparam int PIPE_D = RD_LAT + 1;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  if (!fill_len_ok(ADDR_W, FILL_LEN)) begin : g_fill_len_chk
    $error("embed_ram_sched: FILL_LEN must equal 2**ADDR_W");
  end

  sched_state_t      state_r;
  logic [CNT_W-1:0]  fill_cnt_r;
  logic              start_ack_r;
  logic              frame_done_r;
  logic              switch_r;
  logic              overrun_r;
  logic [ADDR_W-1:0] rd_addr_r;

  logic              fill_en_s;
  logic              rd_gnt_s;
  logic              rd_valid_s;
  logic              pipe_empty_s;

  // Gate the fill stream and the read grant by the current owner of the RAM.
  always_comb begin
    fill_en_s = 1'b0;
    rd_gnt_s  = 1'b0;
    if (state_r == ST_FILL) begin
      fill_en_s = i_fill_valid;
    end else begin
      fill_en_s = 1'b0;
    end
    if (state_r == ST_SERVE) begin
      rd_gnt_s = i_rd_req & ~i_mlp_req & ~i_start;
    end else begin
      rd_gnt_s = 1'b0;
    end
  end

  // Ownership FSM with registered pulse and switch outputs.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_r      <= ST_IDLE;
      fill_cnt_r   <= {CNT_W{1'b0}};
      start_ack_r  <= 1'b0;
      frame_done_r <= 1'b0;
      switch_r     <= 1'b0;
    end else begin
      start_ack_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            state_r     <= ST_FILL;
            start_ack_r <= 1'b1;
            fill_cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ST_FILL: begin
          if (fill_en_s) begin
            if (fill_cnt_r == FILL_LAST) begin
              fill_cnt_r   <= {CNT_W{1'b0}};
              frame_done_r <= 1'b1;
              state_r      <= ST_DRAIN;
            end else begin
              fill_cnt_r <= fill_cnt_r + CNT_ONE;
            end
          end
        end
        ST_DRAIN: begin
          // Covers the patch-embed write register stage.
          state_r <= ST_SERVE;
        end
        ST_SERVE: begin
          if (i_mlp_req) begin
            state_r <= ST_HANDOFF;
          end else if (i_start && pipe_empty_s) begin
            state_r     <= ST_FILL;
            start_ack_r <= 1'b1;
            fill_cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ST_HANDOFF: begin
          if (pipe_empty_s) begin
            state_r  <= ST_MLP;
            switch_r <= 1'b1;
          end
        end
        ST_MLP: begin
          if (i_mlp_done) begin
            state_r  <= ST_SERVE;
            switch_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          switch_r <= 1'b0;
        end
      endcase
    end
  end

  // Flag fill beats that arrive while the RAM is not accepting a frame.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      overrun_r <= 1'b0;
    end else if (i_fill_valid && (state_r != ST_FILL)) begin
      overrun_r <= 1'b1;
    end
  end

  // Register the granted read address onto the RAM read port.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (rd_gnt_s) begin
      rd_addr_r <= i_rd_addr;
    end
  end

  rd_lat_pipe #(
    .DEPTH (PIPE_D)
  ) u_rd_lat_pipe (
    .s_clk   (s_clk),
    .s_rst   (s_rst),
    .i_vld   (rd_gnt_s),
    .o_vld   (rd_valid_s),
    .o_empty (pipe_empty_s)
  );

`ifdef EMBED_SCHED_PERF_EN
  logic [31:0] perf_rd_cnt_r;
  logic [31:0] perf_stall_cnt_r;
  logic        stall_s;

  // A stall is a pending read refused while the RAM is past the fill phase.
  always_comb begin
    stall_s = 1'b0;
    if ((state_r != ST_IDLE) && (state_r != ST_FILL)) begin
      stall_s = i_rd_req & ~rd_gnt_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Saturating grant and stall counters.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      perf_rd_cnt_r    <= 32'd0;
      perf_stall_cnt_r <= 32'd0;
    end else begin
      if (rd_gnt_s && (perf_rd_cnt_r != 32'hFFFF_FFFF)) begin
        perf_rd_cnt_r <= perf_rd_cnt_r + 32'd1;
      end
      if (stall_s && (perf_stall_cnt_r != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
      end
    end
  end

  assign o_perf_rd_cnt    = perf_rd_cnt_r;
  assign o_perf_stall_cnt = perf_stall_cnt_r;
`endif

  assign o_start_ack  = start_ack_r;
  assign o_fill_en    = fill_en_s;
  assign o_rd_gnt     = rd_gnt_s;
  assign o_rd_addr    = rd_addr_r;
  assign o_rd_valid   = rd_valid_s;
  assign o_mlp_gnt    = switch_r;
  assign o_switch     = switch_r;
  assign o_frame_done = frame_done_r;
  assign o_overrun    = overrun_r;
  assign o_state      = state_r;

endmodule

// File: tb/tb_embed_ram_sched.sv
// Self-checking bench for embed_ram_sched. Inputs change 1 ns after the
// rising edge, outputs are sampled on the falling edge.
module tb_embed_ram_sched;

  localparam int ADDR_W   = 12;
  localparam int FILL_LEN = 4096;

  logic              s_clk = 1'b0;
  logic              s_rst;
  logic              i_start;
  logic              o_start_ack;
  logic              i_fill_valid;
  logic              o_fill_en;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_gnt;
  logic [ADDR_W-1:0] o_rd_addr;
  logic              o_rd_valid;
  logic              i_mlp_req;
  logic              o_mlp_gnt;
  logic              i_mlp_done;
  logic              o_switch;
  logic              o_frame_done;
  logic              o_overrun;
  logic [2:0]        o_state;
`ifdef EMBED_SCHED_PERF_EN
  logic [31:0]       o_perf_rd_cnt;
  logic [31:0]       o_perf_stall_cnt;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int rd_q[$];     // expected o_rd_valid cycles, one per grant
  int done_q[$];   // expected o_frame_done cycle

  embed_ram_sched #(
    .ADDR_W   (ADDR_W),
    .FILL_LEN (FILL_LEN),
    .RD_LAT   (2)
  ) dut (
    .s_clk        (s_clk),
    .s_rst        (s_rst),
    .i_start      (i_start),
    .o_start_ack  (o_start_ack),
    .i_fill_valid (i_fill_valid),
    .o_fill_en    (o_fill_en),
    .i_rd_req     (i_rd_req),
    .i_rd_addr    (i_rd_addr),
    .o_rd_gnt     (o_rd_gnt),
    .o_rd_addr    (o_rd_addr),
    .o_rd_valid   (o_rd_valid),
    .i_mlp_req    (i_mlp_req),
    .o_mlp_gnt    (o_mlp_gnt),
    .i_mlp_done   (i_mlp_done),
    .o_switch     (o_switch),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun),
    .o_state      (o_state)
`ifdef EMBED_SCHED_PERF_EN
    ,
    .o_perf_rd_cnt    (o_perf_rd_cnt),
    .o_perf_stall_cnt (o_perf_stall_cnt)
`endif
  );

  always #5 s_clk = ~s_clk;

  always @(posedge s_clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached (tests run %0d)", tests_run);
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge s_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge s_clk);
  endtask

  // Drive random-gap fill beats until `limit` are accepted, then idle `tail` cycles.
  task automatic drive_fill(input int limit, input int tail,
                            output int beats, output int dones, output int done_cyc);
    int n;
    n = 0; beats = 0; dones = 0; done_cyc = -1;
    while (beats < limit && n < 20000) begin
      next_cycle();
      i_fill_valid = ($urandom_range(0, 3) != 0);
      sample();
      if (o_fill_en) begin
        beats++;
        if (beats == FILL_LEN) done_q.push_back(cyc + 1);
      end
      if (o_frame_done) begin dones++; done_cyc = cyc; end
      n++;
    end
    for (int k = 0; k < tail; k++) begin
      next_cycle();
      i_fill_valid = 1'b0;
      sample();
      if (o_frame_done) begin dones++; done_cyc = cyc; end
    end
  endtask

  task automatic test_reset();
    s_rst = 1'b1; i_start = 1'b0; i_fill_valid = 1'b0; i_rd_req = 1'b0;
    i_rd_addr = '0; i_mlp_req = 1'b0; i_mlp_done = 1'b0;
    repeat (3) next_cycle();
    s_rst = 1'b0;
    sample();
    tests_run++;
    if ({o_start_ack, o_fill_en, o_rd_gnt, o_rd_valid, o_mlp_gnt, o_switch,
         o_frame_done, o_overrun, o_rd_addr, o_state} !== 23'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: state=%0d rd_addr=%0h switch=%b overrun=%b, required all 0",
               o_state, o_rd_addr, o_switch, o_overrun);
    end
    // IDLE must refuse reads and MLP ownership.
    next_cycle(); i_rd_req = 1'b1; i_mlp_req = 1'b1; sample();
    tests_run++;
    if (o_rd_gnt !== 1'b0) begin
      tests_failed++; $display("FAIL idle_rd_gnt: got %b, required 0", o_rd_gnt);
    end
    repeat (3) begin next_cycle(); sample(); end
    tests_run++;
    if ({o_switch, o_state} !== 4'b0_000) begin
      tests_failed++; $display("FAIL idle_mlp: switch=%b state=%0d, required 0/0", o_switch, o_state);
    end
    next_cycle(); i_rd_req = 1'b0; i_mlp_req = 1'b0; sample();
  endtask

  task automatic test_fill();
    int got, beats, dones, done_cyc, exp_cyc;
    next_cycle(); i_start = 1'b1; sample();
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      next_cycle(); sample();
      if (o_start_ack) got = 1;
    end
    tests_run++;
    if (got != 1 || o_state !== 3'd1) begin
      tests_failed++; $display("FAIL fill_start_ack: ack=%0d state=%0d, required 1/1", got, o_state);
    end
    i_start = 1'b0;
    drive_fill(FILL_LEN, 4, beats, dones, done_cyc);
    tests_run++;
    if (beats != FILL_LEN) begin
      tests_failed++; $display("FAIL fill_beats: got %0d, required %0d", beats, FILL_LEN);
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++; $display("FAIL fill_done_count: got %0d, required 1", dones);
    end
    exp_cyc = (done_q.size() > 0) ? done_q.pop_front() : -2;
    tests_run++;
    if (done_cyc != exp_cyc) begin
      tests_failed++; $display("FAIL fill_done_time: got cycle %0d, required %0d", done_cyc, exp_cyc);
    end
    tests_run++;
    if ({o_overrun, o_state} !== 4'b0_011) begin
      tests_failed++; $display("FAIL fill_end_state: overrun=%b state=%0d, required 0/3", o_overrun, o_state);
    end
  endtask

  task automatic test_serve_reads();
    int gnts, valids, first_gnt, first_val, prev_gnt, exp;
    logic [ADDR_W-1:0] prev_addr;
    rd_q.delete();
    gnts = 0; valids = 0; first_gnt = -1; first_val = -1; prev_gnt = 0; prev_addr = '0;
    for (int k = 0; k < 40; k++) begin
      if (k >= 16 && rd_q.size() == 0) break;
      next_cycle();
      i_rd_req  = (k < 16);
      i_rd_addr = ADDR_W'(k);
      sample();
      if (prev_gnt != 0) begin
        tests_run++;
        if (o_rd_addr !== prev_addr) begin
          tests_failed++; $display("FAIL rd_addr: got %0h, required %0h", o_rd_addr, prev_addr);
        end
      end
      if (o_rd_valid) begin
        valids++;
        if (first_val < 0) first_val = cyc;
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : -1;
        tests_run++;
        if (cyc != exp) begin
          tests_failed++; $display("FAIL rd_valid_time: got cycle %0d, required %0d", cyc, exp);
        end
      end
      if (k < 16) begin
        tests_run++;
        if (o_rd_gnt !== 1'b1) begin
          tests_failed++; $display("FAIL rd_gnt: addr %0d got %b, required 1", k, o_rd_gnt);
        end
      end
      prev_gnt = o_rd_gnt;
      prev_addr = i_rd_addr;
      if (o_rd_gnt) begin
        gnts++;
        if (first_gnt < 0) first_gnt = cyc;
        rd_q.push_back(cyc + 3);
      end
    end
    tests_run++;
    if (valids != 16 || gnts != 16) begin
      tests_failed++; $display("FAIL rd_totals: valids=%0d grants=%0d, required 16/16", valids, gnts);
    end
    tests_run++;
    if (first_val - first_gnt != 3) begin
      tests_failed++; $display("FAIL rd_first_latency: got %0d, required 3", first_val - first_gnt);
    end
  endtask

  task automatic test_mlp_handoff();
    int late_gnt, last_val, sw_cyc, exp;
    rd_q.delete();
    for (int k = 0; k < 2; k++) begin
      next_cycle(); i_rd_req = 1'b1; i_rd_addr = ADDR_W'(100 + k); sample();
      tests_run++;
      if (o_rd_gnt !== 1'b1) begin
        tests_failed++; $display("FAIL ho_pre_gnt: got %b, required 1", o_rd_gnt);
      end
      if (o_rd_gnt) rd_q.push_back(cyc + 3);
    end
    late_gnt = 0; last_val = -1; sw_cyc = -1;
    for (int n = 0; n < 30 && sw_cyc < 0; n++) begin
      next_cycle(); i_mlp_req = 1'b1; i_rd_req = 1'b1; i_rd_addr = ADDR_W'(200); sample();
      if (o_rd_gnt) late_gnt++;
      if (o_rd_valid) begin
        last_val = cyc;
        exp = (rd_q.size() > 0) ? rd_q.pop_front() : -1;
        tests_run++;
        if (cyc != exp) begin
          tests_failed++; $display("FAIL ho_valid_time: got cycle %0d, required %0d", cyc, exp);
        end
      end
      if (o_switch) sw_cyc = cyc;
    end
    tests_run++;
    if (late_gnt != 0) begin
      tests_failed++; $display("FAIL ho_late_gnt: got %0d grants, required 0", late_gnt);
    end
    tests_run++;
    if (!(sw_cyc >= 0 && last_val >= 0 && sw_cyc > last_val && rd_q.size() == 0)) begin
      tests_failed++; $display("FAIL ho_switch_order: switch cycle %0d, last valid %0d, pending %0d, required switch after last valid",
                               sw_cyc, last_val, rd_q.size());
    end
    tests_run++;
    if ({o_mlp_gnt, o_state} !== 4'b1_101) begin
      tests_failed++; $display("FAIL ho_mlp_state: mlp_gnt=%b state=%0d, required 1/5", o_mlp_gnt, o_state);
    end
    next_cycle(); i_mlp_done = 1'b1; i_mlp_req = 1'b0; sample();
    tests_run++;
    if ({o_switch, o_rd_gnt} !== 2'b10) begin
      tests_failed++; $display("FAIL ho_done_cycle: switch=%b gnt=%b, required 1/0", o_switch, o_rd_gnt);
    end
    next_cycle(); i_mlp_done = 1'b0; i_rd_addr = ADDR_W'(300); sample();
    tests_run++;
    if ({o_switch, o_rd_gnt, o_state} !== 5'b0_1_011) begin
      tests_failed++; $display("FAIL ho_resume: switch=%b gnt=%b state=%0d, required 0/1/3", o_switch, o_rd_gnt, o_state);
    end
    if (o_rd_gnt) rd_q.push_back(cyc + 3);
    for (int n = 0; n < 10 && rd_q.size() > 0; n++) begin
      next_cycle(); i_rd_req = 1'b0; sample();
      if (o_rd_valid) begin
        exp = rd_q.pop_front();
        tests_run++;
        if (cyc != exp) begin
          tests_failed++; $display("FAIL ho_resume_valid: got cycle %0d, required %0d", cyc, exp);
        end
      end
    end
    i_rd_req = 1'b0;
    tests_run++;
    if (rd_q.size() != 0) begin
      tests_failed++; $display("FAIL ho_resume_pending: %0d reads without valid, required 0", rd_q.size());
    end
  endtask

  task automatic test_overrun();
    int got;
    next_cycle(); sample();
    tests_run++;
    if (o_overrun !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_initial: got %b, required 0", o_overrun);
    end
    next_cycle(); i_fill_valid = 1'b1; sample();
    tests_run++;
    if (o_fill_en !== 1'b0) begin
      tests_failed++; $display("FAIL ovr_serve_fill_en: got %b, required 0", o_fill_en);
    end
    // A stray mlp_done in SERVE must not change state.
    next_cycle(); i_fill_valid = 1'b0; i_mlp_done = 1'b1; sample();
    tests_run++;
    if ({o_overrun, o_state} !== 4'b1_011) begin
      tests_failed++; $display("FAIL ovr_serve_set: overrun=%b state=%0d, required 1/3", o_overrun, o_state);
    end
    next_cycle(); i_mlp_done = 1'b0; i_mlp_req = 1'b1; sample();
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      next_cycle(); sample();
      if (o_switch) got = 1;
    end
    next_cycle(); i_fill_valid = 1'b1; sample();
    tests_run++;
    if ({got[0], o_switch, o_fill_en} !== 3'b110) begin
      tests_failed++; $display("FAIL ovr_mlp_fill_en: granted=%0d switch=%b fill_en=%b, required 1/1/0", got, o_switch, o_fill_en);
    end
    next_cycle(); i_fill_valid = 1'b0; i_mlp_done = 1'b1; i_mlp_req = 1'b0; sample();
    next_cycle(); i_mlp_done = 1'b0; sample();
    tests_run++;
    if ({o_overrun, o_switch} !== 2'b10) begin
      tests_failed++; $display("FAIL ovr_sticky: overrun=%b switch=%b, required 1/0", o_overrun, o_switch);
    end
  endtask

  task automatic test_start_vs_mlp();
    int early_ack, got, ack_state;
    next_cycle(); i_start = 1'b1; i_mlp_req = 1'b1; sample();
    early_ack = o_start_ack ? 1 : 0;
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      next_cycle(); sample();
      if (o_start_ack) early_ack++;
      if (o_switch) got = 1;
    end
    tests_run++;
    if (got != 1 || early_ack != 0 || o_state !== 3'd5) begin
      tests_failed++; $display("FAIL sm_mlp_first: granted=%0d early_acks=%0d state=%0d, required 1/0/5", got, early_ack, o_state);
    end
    next_cycle(); i_mlp_done = 1'b1; i_mlp_req = 1'b0; sample();
    got = 0; ack_state = -1;
    for (int n = 0; n < 10 && got == 0; n++) begin
      next_cycle(); i_mlp_done = 1'b0; sample();
      if (o_start_ack) begin got = 1; ack_state = int'(o_state); end
    end
    tests_run++;
    if (got != 1 || ack_state != 1) begin
      tests_failed++; $display("FAIL sm_start_ack: ack=%0d state=%0d, required 1/1", got, ack_state);
    end
    next_cycle(); i_start = 1'b0; sample();
    tests_run++;
    if ({o_start_ack, o_state} !== 4'b0_001) begin
      tests_failed++; $display("FAIL sm_ack_pulse: ack=%b state=%0d, required 0/1", o_start_ack, o_state);
    end
  endtask

  task automatic test_reset_mid_fill();
    int beats, dones, done_cyc, got, exp_cyc;
    drive_fill(1000, 0, beats, dones, done_cyc);
    tests_run++;
    if (beats != 1000 || dones != 0) begin
      tests_failed++; $display("FAIL rst_pre_fill: beats=%0d dones=%0d, required 1000/0", beats, dones);
    end
    next_cycle(); s_rst = 1'b1; i_fill_valid = 1'b0; sample();
    next_cycle(); s_rst = 1'b0; sample();
    tests_run++;
    if ({o_start_ack, o_fill_en, o_rd_gnt, o_rd_valid, o_mlp_gnt, o_switch,
         o_frame_done, o_overrun, o_rd_addr, o_state} !== 23'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: state=%0d overrun=%b rd_addr=%0h, required all 0", o_state, o_overrun, o_rd_addr);
    end
`ifdef EMBED_SCHED_PERF_EN
    tests_run++;
    if ({o_perf_rd_cnt, o_perf_stall_cnt} !== 64'd0) begin
      tests_failed++; $display("FAIL rst_perf: rd=%0d stall=%0d, required 0/0", o_perf_rd_cnt, o_perf_stall_cnt);
    end
`endif
    next_cycle(); i_start = 1'b1; sample();
    got = 0;
    for (int n = 0; n < 10 && got == 0; n++) begin
      next_cycle(); sample();
      if (o_start_ack) got = 1;
    end
    i_start = 1'b0;
    tests_run++;
    if (got != 1) begin
      tests_failed++; $display("FAIL rst_restart_ack: got %0d, required 1", got);
    end
    done_q.delete();
    drive_fill(FILL_LEN, 4, beats, dones, done_cyc);
    exp_cyc = (done_q.size() > 0) ? done_q.pop_front() : -2;
    tests_run++;
    if (beats != FILL_LEN || dones != 1 || done_cyc != exp_cyc) begin
      tests_failed++; $display("FAIL rst_refill: beats=%0d dones=%0d done_cycle=%0d, required %0d/1/%0d",
                               beats, dones, done_cyc, FILL_LEN, exp_cyc);
    end
    tests_run++;
    if ({o_overrun, o_state} !== 4'b0_011) begin
      tests_failed++; $display("FAIL rst_refill_state: overrun=%b state=%0d, required 0/3", o_overrun, o_state);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_serve_reads();
    test_mlp_handoff();
    test_overrun();
    test_start_vs_mlp();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
